tod_timer_ctrl: RTL and testbench

TOD_TIMER_CTRL -- requirements
Module: tod_timer_ctrl

---
 rtl/tod_pkg.sv | 25 ++
 rtl/tod_prescaler.sv | 50 +++++
 rtl/tod_timer_ctrl.sv | 141 ++++++++++++++
 tb/tb_tod_timer_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tod_pkg.sv
// Shared definitions for the time-of-day timer: register map, CTRL/STATUS
// bit positions and the prescaler state encoding.
package tod_pkg;

    typedef enum logic [2:0] {
        ADDR_CTRL     = 3'd0,
        ADDR_STATUS   = 3'd1,
        ADDR_TOD_LO   = 3'd2,
        ADDR_TOD_HI   = 3'd3,
        ADDR_ALARM_LO = 3'd4,
        ADDR_ALARM_HI = 3'd5,
        ADDR_RSVD6    = 3'd6,
        ADDR_RSVD7    = 3'd7
    } tod_addr_e;

    localparam int CTRL_RUN_BIT         = 0;
    localparam int CTRL_ALARM_EN_BIT    = 1;
    localparam int STATUS_ALARM_HIT_BIT = 0;
    localparam int STATUS_WRAP_BIT      = 1;

    typedef logic [0:0] presc_state_t;
    localparam presc_state_t PS_STOPPED = 1'b0;
    localparam presc_state_t PS_RUNNING = 1'b1;

endpackage

// File: rtl/tod_prescaler.sv
// Divides CLOCK by P_PRESCALE while running; tick is a combinational wrap
// strobe that the top registers together with the time-of-day increment.
module tod_prescaler
    import tod_pkg::*;
#(
    parameter int P_PRESCALE = 100
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int             CW   = (P_PRESCALE > 2) ? $clog2(P_PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(P_PRESCALE - 1);

    presc_state_t  state;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign state = run ? PS_RUNNING : PS_STOPPED;

    // A clear (time load) restarts the period and swallows a coincident wrap.
    always_comb begin
        count_next = '0;
        tick       = 1'b0;
        case (state)
            PS_RUNNING: begin
                if (clear) begin
                    count_next = '0;
                end else if (count_reg == LAST) begin
                    count_next = '0;
                    tick       = 1'b1;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            default: count_next = '0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/tod_timer_ctrl.sv
// Time-of-day counter with register interface, atomic 64-bit style load/read
// through HI shadow/latch, alarm compare and sticky wrap status.
module tod_timer_ctrl
    import tod_pkg::*;
#(
    parameter int P_PRESCALE  = 100,
    parameter int P_TOD_WIDTH = 48
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    input  logic [2:0]             ADDR,
    input  logic                   WRITE,
    input  logic                   READ,
    input  logic [31:0]            WDATA,
    output logic [31:0]            RDATA_Q,
    output logic                   RVALID_Q,
    output logic [P_TOD_WIDTH-1:0] TOD_Q,
    output logic                   TICK_Q,
    output logic                   IRQ_Q
);
    localparam int HI_W = P_TOD_WIDTH - 32;

    tod_addr_e              addr;
    logic                   wr_ctrl, wr_status, wr_tod_lo, wr_tod_hi;
    logic                   wr_alarm_lo, wr_alarm_hi, rd_tod_lo;
    logic                   run_reg, alarm_en_reg;
    logic                   hit_reg, hit_next, wrap_reg, wrap_next;
    logic                   tod_event_reg;
    logic                   presc_tick, set_hit, set_wrap;
    logic [HI_W-1:0]        hi_shadow_reg, hi_latch_reg;
    logic [P_TOD_WIDTH-1:0] alarm_reg, tod_next;
    logic [31:0]            rdata_next;

    assign addr        = tod_addr_e'(ADDR);
    assign wr_ctrl     = WRITE && (addr == ADDR_CTRL);
    assign wr_status   = WRITE && (addr == ADDR_STATUS);
    assign wr_tod_lo   = WRITE && (addr == ADDR_TOD_LO);
    assign wr_tod_hi   = WRITE && (addr == ADDR_TOD_HI);
    assign wr_alarm_lo = WRITE && (addr == ADDR_ALARM_LO);
    assign wr_alarm_hi = WRITE && (addr == ADDR_ALARM_HI);
    assign rd_tod_lo   = READ  && (addr == ADDR_TOD_LO);

    tod_prescaler #(
        .P_PRESCALE(P_PRESCALE)
    ) u_prescaler (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .run    (run_reg),
        .clear  (wr_tod_lo),
        .tick   (presc_tick)
    );

    always_comb begin
        tod_next = TOD_Q;
        if (wr_tod_lo) begin
            tod_next = {hi_shadow_reg, WDATA};
        end else if (presc_tick) begin
            tod_next = TOD_Q + P_TOD_WIDTH'(1);
        end
    end

    // The alarm compare looks at TOD_Q one cycle after it changed by tick or load.
    assign set_hit  = tod_event_reg && (TOD_Q == alarm_reg);
    assign set_wrap = presc_tick && (&TOD_Q);

    always_comb begin
        hit_next  = hit_reg;
        wrap_next = wrap_reg;
        if (wr_status) begin
            hit_next  = hit_reg  & ~WDATA[STATUS_ALARM_HIT_BIT];
            wrap_next = wrap_reg & ~WDATA[STATUS_WRAP_BIT];
        end
        hit_next  = hit_next  | set_hit;
        wrap_next = wrap_next | set_wrap;
    end

    always_comb begin
        rdata_next = '0;
        case (addr)
            ADDR_CTRL: begin
                rdata_next[CTRL_RUN_BIT]      = run_reg;
                rdata_next[CTRL_ALARM_EN_BIT] = alarm_en_reg;
            end
            ADDR_STATUS: begin
                rdata_next[STATUS_ALARM_HIT_BIT] = hit_reg;
                rdata_next[STATUS_WRAP_BIT]      = wrap_reg;
            end
            ADDR_TOD_LO:   rdata_next = TOD_Q[31:0];
            ADDR_TOD_HI:   rdata_next = 32'(hi_latch_reg);
            ADDR_ALARM_LO: rdata_next = alarm_reg[31:0];
            ADDR_ALARM_HI: rdata_next = 32'(alarm_reg[P_TOD_WIDTH-1:32]);
            default:       rdata_next = '0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            TOD_Q         <= '0;
            TICK_Q        <= 1'b0;
            RDATA_Q       <= '0;
            RVALID_Q      <= 1'b0;
            run_reg       <= 1'b0;
            alarm_en_reg  <= 1'b0;
            hit_reg       <= 1'b0;
            wrap_reg      <= 1'b0;
            tod_event_reg <= 1'b0;
            hi_shadow_reg <= '0;
            hi_latch_reg  <= '0;
            alarm_reg     <= '0;
        end else begin
            TOD_Q         <= tod_next;
            TICK_Q        <= presc_tick;
            tod_event_reg <= presc_tick || wr_tod_lo;
            hit_reg       <= hit_next;
            wrap_reg      <= wrap_next;
            RVALID_Q      <= READ;
            if (READ) begin
                RDATA_Q <= rdata_next;
            end
            if (rd_tod_lo) begin
                hi_latch_reg <= TOD_Q[P_TOD_WIDTH-1:32];
            end
            if (wr_ctrl) begin
                run_reg      <= WDATA[CTRL_RUN_BIT];
                alarm_en_reg <= WDATA[CTRL_ALARM_EN_BIT];
            end
            if (wr_tod_hi) begin
                hi_shadow_reg <= WDATA[HI_W-1:0];
            end
            if (wr_alarm_lo) begin
                alarm_reg[31:0] <= WDATA;
            end
            if (wr_alarm_hi) begin
                alarm_reg[P_TOD_WIDTH-1:32] <= WDATA[HI_W-1:0];
            end
        end
    end

    assign IRQ_Q = hit_reg & alarm_en_reg;

endmodule

// File: tb/tb_tod_timer_ctrl.sv
// Bench for tod_timer_ctrl: directed scenarios plus random register traffic,
// all cross-checked every cycle against a cycle-level reference model.
module tb_tod_timer_ctrl;
    localparam int P = 4;
    localparam int W = 48;

    logic          CLOCK;
    logic          RESET_N;
    logic [2:0]    ADDR;
    logic          WRITE;
    logic          READ;
    logic [31:0]   WDATA;
    logic [31:0]   RDATA_Q;
    logic          RVALID_Q;
    logic [W-1:0]  TOD_Q;
    logic          TICK_Q;
    logic          IRQ_Q;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0]  m_tod, m_alarm;
    logic [15:0]   m_shadow, m_latch;
    logic          m_run, m_alarm_en, m_hit, m_wrap, m_pending, m_tick, m_rvalid;
    logic [31:0]   m_rdata;
    int            m_elapsed;

    tod_timer_ctrl #(.P_PRESCALE(P), .P_TOD_WIDTH(W)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .ADDR    (ADDR),
        .WRITE   (WRITE),
        .READ    (READ),
        .WDATA   (WDATA),
        .RDATA_Q (RDATA_Q),
        .RVALID_Q(RVALID_Q),
        .TOD_Q   (TOD_Q),
        .TICK_Q  (TICK_Q),
        .IRQ_Q   (IRQ_Q)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic model_reset();
        m_tod = '0; m_alarm = '0; m_shadow = '0; m_latch = '0;
        m_run = 0; m_alarm_en = 0; m_hit = 0; m_wrap = 0; m_pending = 0;
        m_tick = 0; m_rvalid = 0; m_rdata = '0; m_elapsed = 0;
    endtask

    // One clock: advance the model using the inputs seen at the edge, then compare.
    task automatic step();
        logic [31:0]  rd_val;
        logic [W-1:0] tod_new;
        logic         set_hit, set_wrap, load;
        @(posedge CLOCK);
        case (ADDR)
            3'd0:    rd_val = {30'd0, m_alarm_en, m_run};
            3'd1:    rd_val = {30'd0, m_wrap, m_hit};
            3'd2:    rd_val = m_tod[31:0];
            3'd3:    rd_val = {16'd0, m_latch};
            3'd4:    rd_val = m_alarm[31:0];
            3'd5:    rd_val = {16'd0, m_alarm[47:32]};
            default: rd_val = 32'd0;
        endcase
        load     = WRITE && (ADDR == 3'd2);
        set_hit  = m_pending && (m_tod == m_alarm);
        set_wrap = 0;
        m_tick   = 0;
        tod_new  = m_tod;
        if (load) begin
            tod_new   = {m_shadow, WDATA};
            m_elapsed = 0;
        end else if (m_run) begin
            m_elapsed++;
            if (m_elapsed == P) begin
                m_tick    = 1;
                m_elapsed = 0;
                set_wrap  = (m_tod == {W{1'b1}});
                tod_new   = m_tod + 1;
            end
        end else begin
            m_elapsed = 0;
        end
        m_pending = load || m_tick;
        if (READ && ADDR == 3'd2) m_latch = m_tod[47:32];
        m_rvalid = READ;
        if (READ) m_rdata = rd_val;
        m_tod = tod_new;
        if (WRITE && ADDR == 3'd1) begin
            m_hit  = m_hit  & ~WDATA[0];
            m_wrap = m_wrap & ~WDATA[1];
        end
        m_hit  = m_hit | set_hit;
        m_wrap = m_wrap | set_wrap;
        if (WRITE && ADDR == 3'd0) begin
            m_run      = WDATA[0];
            m_alarm_en = WDATA[1];
        end
        if (WRITE && ADDR == 3'd3) m_shadow = WDATA[15:0];
        if (WRITE && ADDR == 3'd4) m_alarm[31:0] = WDATA;
        if (WRITE && ADDR == 3'd5) m_alarm[47:32] = WDATA[15:0];
        #1;
        checks++;
        if (TOD_Q !== m_tod) begin
            errors++; $display("FAIL model_tod: got %h expected %h", TOD_Q, m_tod);
        end
        checks++;
        if (TICK_Q !== m_tick) begin
            errors++; $display("FAIL model_tick: got %b expected %b", TICK_Q, m_tick);
        end
        checks++;
        if (IRQ_Q !== (m_hit & m_alarm_en)) begin
            errors++; $display("FAIL model_irq: got %b expected %b", IRQ_Q, m_hit & m_alarm_en);
        end
        checks++;
        if (RVALID_Q !== m_rvalid || RDATA_Q !== m_rdata) begin
            errors++;
            $display("FAIL model_read: got v=%b d=%h expected v=%b d=%h", RVALID_Q, RDATA_Q, m_rvalid, m_rdata);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        $display("WR addr=%0d data=%h", a, d);
        ADDR = a; WDATA = d; WRITE = 1'b1;
        step();
        WRITE = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        READ = 1'b1; ADDR = a;
        step();
        READ = 1'b0;
        d = RDATA_Q;
        $display("RD addr=%0d data=%h valid=%b", a, d, RVALID_Q);
    endtask

    task automatic wait_tick(input int max, output bit got);
        got = 0;
        for (int i = 0; i < max && !got; i++) begin
            step();
            if (TICK_Q === 1'b1) got = 1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RESET_N = 1'b0; ADDR = '0; WRITE = 0; READ = 0; WDATA = '0;
        model_reset();
        repeat (3) @(posedge CLOCK);
        #1 RESET_N = 1'b1;
        checks++;
        if (TOD_Q !== '0 || TICK_Q !== 0 || IRQ_Q !== 0 || RVALID_Q !== 0 || RDATA_Q !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tod=%h tick=%b irq=%b rv=%b rd=%h required all 0",
                     TOD_Q, TICK_Q, IRQ_Q, RVALID_Q, RDATA_Q);
        end
        do_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        do_read(3'd1, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
    endtask

    task automatic test_tick_period();
        do_write(3'd0, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (TICK_Q !== ((k % 4) == 0) || TOD_Q !== W'(k / 4)) begin
                errors++;
                $display("FAIL tick_period cycle %0d: got tick=%b tod=%0d expected tick=%b tod=%0d",
                         k, TICK_Q, TOD_Q, (k % 4) == 0, k / 4);
            end
        end
        do_write(3'd0, 32'd0);
    endtask

    task automatic test_load();
        bit got;
        do_write(3'd3, 32'h1234);
        checks++;
        if (TOD_Q !== 48'd3) begin errors++; $display("FAIL hi_shadow_no_effect: got %h expected 3", TOD_Q); end
        do_write(3'd2, 32'hFFFF_FFFF);
        checks++;
        if (TOD_Q !== 48'h1234_FFFF_FFFF) begin
            errors++; $display("FAIL load: got %h expected 1234ffffffff", TOD_Q);
        end
        do_write(3'd0, 32'd1);
        wait_tick(8, got);
        checks++;
        if (!got || TOD_Q !== 48'h1235_0000_0000) begin
            errors++; $display("FAIL load_carry: got tick=%b tod=%h expected tod=123500000000", got, TOD_Q);
        end
        do_write(3'd0, 32'd0);
    endtask

    task automatic test_hi_latch();
        logic [31:0] d;
        bit got;
        do_write(3'd3, 32'h0);
        do_write(3'd2, 32'hFFFF_FFFF);
        do_write(3'd0, 32'd1);
        do_read(3'd2, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL latch_lo: got %h expected ffffffff", d); end
        wait_tick(8, got);
        checks++;
        if (!got || TOD_Q[47:32] !== 16'd1) begin
            errors++; $display("FAIL latch_tick: got tick=%b tod=%h expected upper=1", got, TOD_Q);
        end
        do_read(3'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL latch_hi: got %h expected 0", d); end
        do_write(3'd0, 32'd0);
    endtask

    task automatic test_alarm();
        logic [31:0] d;
        bit hit5;
        do_write(3'd5, 32'd0);
        do_write(3'd4, 32'd5);
        do_write(3'd3, 32'd0);
        do_write(3'd2, 32'd0);
        do_write(3'd1, 32'd3);
        do_write(3'd0, 32'd3);
        hit5 = 0;
        for (int i = 0; i < 40 && !hit5; i++) begin
            step();
            if (TOD_Q === 48'd5) hit5 = 1;
        end
        checks++;
        if (!hit5 || IRQ_Q !== 1'b0) begin
            errors++; $display("FAIL alarm_reach: got reached=%b irq=%b expected reached=1 irq=0", hit5, IRQ_Q);
        end
        step();
        checks++;
        if (IRQ_Q !== 1'b1) begin errors++; $display("FAIL alarm_irq: got %b expected 1", IRQ_Q); end
        do_read(3'd1, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL alarm_status: got %h expected 1", d); end
        do_write(3'd1, 32'd1);
        checks++;
        if (IRQ_Q !== 1'b0) begin errors++; $display("FAIL alarm_clear: got %b expected 0", IRQ_Q); end
        do_write(3'd0, 32'd0);
    endtask

    task automatic test_load_on_wrap();
        do_write(3'd3, 32'd0);
        do_write(3'd2, 32'h100);
        do_write(3'd0, 32'd1);
        repeat (3) step();
        do_write(3'd2, 32'hABCD);
        checks++;
        if (TOD_Q !== 48'hABCD || TICK_Q !== 1'b0) begin
            errors++; $display("FAIL load_wins: got tod=%h tick=%b expected tod=abcd tick=0", TOD_Q, TICK_Q);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (TICK_Q !== (k == 4)) begin
                errors++; $display("FAIL load_next_tick cycle %0d: got %b expected %b", k, TICK_Q, k == 4);
            end
        end
        checks++;
        if (TOD_Q !== 48'hABCE) begin errors++; $display("FAIL load_next_tod: got %h expected abce", TOD_Q); end
        do_write(3'd0, 32'd0);
    endtask

    task automatic test_wrap_reset();
        logic [31:0] d;
        bit got;
        do_write(3'd3, 32'hFFFF);
        do_write(3'd2, 32'hFFFF_FFFF);
        do_write(3'd1, 32'd3);
        do_write(3'd0, 32'd1);
        wait_tick(8, got);
        checks++;
        if (!got || TOD_Q !== '0) begin
            errors++; $display("FAIL wrap_tod: got tick=%b tod=%h expected 0", got, TOD_Q);
        end
        do_read(3'd1, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL wrap_status: got %h expected 2", d); end
        step();
        step();
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (TOD_Q !== '0 || TICK_Q !== 0 || IRQ_Q !== 0 || RVALID_Q !== 0 || RDATA_Q !== '0) begin
            errors++;
            $display("FAIL midreset: got tod=%h tick=%b irq=%b rv=%b rd=%h required all 0",
                     TOD_Q, TICK_Q, IRQ_Q, RVALID_Q, RDATA_Q);
        end
        model_reset();
        @(posedge CLOCK);
        #1 RESET_N = 1'b1;
        do_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL midreset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                step();
            end else if (op < 7) begin
                ADDR = 3'($urandom_range(0, 5));
                case (ADDR)
                    3'd0:    d = $urandom_range(0, 15);
                    3'd2:    d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom;
                    3'd3:    d = ($urandom_range(0, 1) == 1) ? 32'hFFFF : $urandom;
                    3'd4:    d = m_tod[31:0] + $urandom_range(0, 3);
                    3'd5:    d = {16'd0, m_tod[47:32]};
                    default: d = $urandom;
                endcase
                do_write(ADDR, d);
            end else begin
                do_read(3'($urandom_range(0, 7)), d);
            end
        end
        do_write(3'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_load();
        test_hi_latch();
        test_alarm();
        test_load_on_wrap();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
